// File: rtl/cp0_pkg.sv
// Shared CP0 constants: register numbers, PrID, handler vector, ExcCodes.
package cp0_pkg;

    localparam int unsigned REG_AW  = 5;
    localparam int unsigned DATA_W  = 32;

    localparam logic [REG_AW-1:0] CP0_SR    = 5'd12;
    localparam logic [REG_AW-1:0] CP0_CAUSE = 5'd13;
    localparam logic [REG_AW-1:0] CP0_EPC   = 5'd14;
    localparam logic [REG_AW-1:0] CP0_PRID  = 5'd15;

    localparam logic [DATA_W-1:0] PRID_VALUE  = 32'h0000_4D49;
    localparam logic [DATA_W-1:0] HANDLER_VEC = 32'h0000_4180;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Pending-event summary produced by the priority function.
    typedef struct packed {
        logic int_pend;
        logic exc_pend;
    } pend_t;

endpackage

// File: rtl/cp0_regs.sv
// CP0 register file (SR, Cause, EPC, PrID) with exception/interrupt entry and eret.
// Optional macro CP0_BD_EN enables branch-delay-slot tracking (Cause.BD, EPC-4).
module cp0_regs
    import cp0_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    input  logic        wr_en,
    input  logic [4:0]  wr_addr,
    input  logic [31:0] wr_data,
    input  logic [31:0] victim_pc,
    input  logic        victim_bd,
    input  logic [4:0]  exc_code,
    input  logic [5:0]  hw_int,
    input  logic        eret,
    output logic        exc_req,
    output logic [31:0] epc_out
);

    logic [5:0]  r_sr_im;
    logic        r_sr_exl;
    logic        r_sr_ie;
    logic        r_cause_bd;
    logic [5:0]  r_cause_ip;
    logic [4:0]  r_cause_exc;
    logic [31:2] r_epc;

    pend_t       w_pend;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_victim_epc;
    logic        w_victim_bd;
    logic        w_wr_sr;
    logic        w_wr_epc;

    // Interrupts need IE and an unmasked line; both kinds are blocked while in a handler.
    function automatic pend_t f_pend(
        input logic [5:0] hw,
        input logic [5:0] im,
        input logic       ie,
        input logic       exl,
        input logic [4:0] code
    );
        pend_t p;
        p.int_pend = (|(hw & im)) & ie & ~exl;
        p.exc_pend = (code != 5'd0) & ~exl;
        return p;
    endfunction

    assign w_pend  = f_pend(hw_int, r_sr_im, r_sr_ie, r_sr_exl, exc_code);
    assign exc_req = w_pend.int_pend | w_pend.exc_pend;

    assign w_sr    = {16'b0, r_sr_im, 8'b0, r_sr_exl, r_sr_ie};
    assign w_cause = {r_cause_bd, 15'b0, r_cause_ip, 3'b0, r_cause_exc, 2'b0};
    assign epc_out = {r_epc, 2'b00};

    assign w_wr_sr  = wr_en && (wr_addr == CP0_SR);
    assign w_wr_epc = wr_en && (wr_addr == CP0_EPC);

`ifdef CP0_BD_EN
    // Delay-slot victims restart at the branch, one word earlier.
    assign w_victim_bd  = victim_bd;
    assign w_victim_epc = victim_bd ? (victim_pc - 32'd4) : victim_pc;
    logic w_unused_ok;
    assign w_unused_ok = ^{w_victim_epc[1:0]};
`else
    assign w_victim_bd  = 1'b0;
    assign w_victim_epc = victim_pc;
    logic w_unused_ok;
    assign w_unused_ok = ^{victim_bd, w_victim_epc[1:0]};
`endif

    // mfc0 read mux over the pre-edge register contents.
    always_comb begin
        rd_data = 32'd0;
        case (rd_addr)
            CP0_SR:    rd_data = w_sr;
            CP0_CAUSE: rd_data = w_cause;
            CP0_EPC:   rd_data = {r_epc, 2'b00};
            CP0_PRID:  rd_data = PRID_VALUE;
            default:   rd_data = 32'd0;
        endcase
    end

    // State update: reset, then exception entry, then eret/mtc0.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sr_im     <= 6'd0;
            r_sr_exl    <= 1'b0;
            r_sr_ie     <= 1'b0;
            r_cause_bd  <= 1'b0;
            r_cause_ip  <= 6'd0;
            r_cause_exc <= 5'd0;
            r_epc       <= 30'd0;
        end else begin
            r_cause_ip <= hw_int;
            if (exc_req) begin
                r_sr_exl    <= 1'b1;
                r_cause_exc <= w_pend.int_pend ? EXC_INT : exc_code;
                r_cause_bd  <= w_victim_bd;
                r_epc       <= w_victim_epc[31:2];
            end else begin
                if (w_wr_sr) begin
                    r_sr_im  <= wr_data[15:10];
                    r_sr_ie  <= wr_data[0];
                    r_sr_exl <= wr_data[1] & ~eret;
                end else if (eret) begin
                    r_sr_exl <= 1'b0;
                end
                if (w_wr_epc) begin
                    r_epc <= wr_data[31:2];
                end
            end
        end
    end

endmodule

// File: doc/cp0_regs.md
CP0_REGS -- requirements
Module: cp0_regs

Interface
REQ-001 clk  input  1  single clock; all state updates on the rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 rd_addr  input  5  CP0 register number read by mfc0.
REQ-004 rd_data  output  32  combinational read of the currently held register value selected by rd_addr; unimplemented numbers read 0.
REQ-005 wr_en  input  1  mtc0 write strobe.
REQ-006 wr_addr  input  5  mtc0 target register number.
REQ-007 wr_data  input  32  mtc0 write data.
REQ-008 victim_pc  input  32  PC of the instruction at the commit point (M stage).
REQ-009 victim_bd  input  1  the victim instruction sits in a branch delay slot.
REQ-010 exc_code  input  5  synchronous exception code from the pipeline; 0 means none.
REQ-011 hw_int  input  6  external interrupt lines; the system interrupt pin is bit 2.
REQ-012 eret  input  1  eret is committing this cycle.
REQ-013 exc_req  output  1  combinational flush-and-redirect request to the pipeline.
REQ-014 epc_out  output  32  current EPC value for the eret target.

Function
REQ-015 Register map: SR is 12, Cause is 13, EPC is 14, PrID is 15.
REQ-016 SR fields: IM[15:10], EXL[1], IE[0]; all other bits read 0.
REQ-017 Cause fields: BD[31], IP[15:10], ExcCode[6:2]; all other bits read 0.
REQ-018 PrID reads the package constant 32'h0000_4D49; writes to it are ignored.
REQ-019 int_pend = |(hw_int & SR.IM) & SR.IE & ~SR.EXL.
REQ-020 exc_pend = (exc_code != 0) & ~SR.EXL.
REQ-021 exc_req = int_pend | exc_pend.
REQ-022 Cause.IP is loaded from hw_int every cycle, independent of EXL and IE.
REQ-023 When exc_req is high, the next edge sets SR.EXL to 1.
REQ-024 When exc_req is high and int_pend is high, the next edge writes Cause.ExcCode = 0; interrupt has priority over exc_pend.
REQ-025 When exc_req is high and int_pend is low, the next edge writes Cause.ExcCode = exc_code.
REQ-026 When exc_req is high, the next edge writes Cause.BD and EPC (see REQ-036 and REQ-037).
REQ-027 EPC bits [1:0] are always stored as 0.
REQ-028 When exc_req is low, eret=1 clears SR.EXL on the next edge.
REQ-029 When exc_req is low, mtc0 writes SR (IM, EXL and IE only) or EPC; Cause is read-only to software.
REQ-030 Simultaneous events: exc_req beats eret, and eret beats mtc0 to SR.EXL; mtc0 to EPC in the same cycle as exc_req is discarded.
REQ-031 rd_data and epc_out show the pre-edge values; there is no write-through bypass inside the block.

Reset
REQ-032 On reset, SR, Cause and EPC are 0 on the next edge, so IE=0, EXL=0, IM=0 and BD=0.
REQ-033 Reset overrides exc_req, eret and wr_en in the same cycle.
REQ-034 Asserting reset during a handler (EXL=1) discards all state; no request is held over.

Configuration
REQ-035 Macro CP0_BD_EN selects delay-slot tracking.
REQ-036 With CP0_BD_EN defined: on an exception, Cause.BD <= victim_bd and EPC <= victim_bd ? victim_pc-4 : victim_pc.
REQ-037 Without CP0_BD_EN: Cause.BD always reads 0, EPC <= victim_pc, and victim_bd is ignored.

Structure
REQ-038 The shared package cp0_pkg holds the register numbers 12 to 15, the PrID constant, the handler vector 32'h0000_4180 and the ExcCode constants (Int=0, AdEL=4, AdES=5, RI=10, Ov=12).
REQ-039 The block has no sub-modules; the pending/priority logic is an internal function.

Verification
REQ-040 Interrupt entry: mtc0 SR=32'h0000_FC01, then hw_int=6'b000100 with victim_pc=32'h0000_3024 -> exc_req=1 that cycle; next cycle Cause=32'h0000_1000, EPC=32'h0000_3024, SR.EXL=1, exc_req=0.
REQ-041 Masked interrupt: SR=32'h0000_0001 (IM=0) with hw_int=6'b111111 -> exc_req stays 0; Cause reads 32'h0000_FC00.
REQ-042 Delay-slot exception with CP0_BD_EN: exc_code=12, victim_bd=1, victim_pc=32'h0000_3010 -> EPC=32'h0000_300C, Cause=32'h8000_0030.
REQ-043 Simultaneous events: exc_code=4 and hw_int[2]=1 with IE=1 -> ExcCode=0; a same-cycle eret leaves EXL=1; a same-cycle mtc0 EPC=32'h0000_1234 is dropped.
REQ-044 eret and re-entry: eret=1 with EXL=1 -> EXL=0 next cycle; with hw_int still high, exc_req re-asserts the following cycle.
REQ-045 Reset mid-handler: EXL=1 and EPC=32'h0000_3024, pulse reset -> SR=Cause=EPC=0 and exc_req=0 while hw_int=0.
